noise_scaler: RTL and testbench
===============================

NOISE_SCALER -- requirements
Module: noise_scaler

Interface
REQ-001 Parameter DATA_W, default 20: signed sample width, in and out.
REQ-002 Parameter LFSR_W, default 16: pseudorandom state width; epsilon is unsigned with FRAC_BITS fractional bits.
REQ-003 Parameter FRAC_BITS, default 15: right-shift applied to each product; must be less than LFSR_W + DATA_W.
REQ-004 Parameter TAPS, default 16'hB400: Galois feedback mask, LFSR_W bits wide.
REQ-005 Parameter SEED, default 16'h2E92: reset and fallback LFSR state; must be non-zero.
REQ-006 clk  input  1  global clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 mode  input  1  0 = bypass (output equals input), 1 = scale by epsilon; sampled on each accepted beat.
REQ-009 seed_load  input  1  single-cycle request to load seed_val into the LFSR.
REQ-010 seed_val  input  LFSR_W  seed value for seed_load.
REQ-011 in_valid / in_ready  input / output  1 each  input handshake; in_data is accepted when both are high.
REQ-012 in_data  input  DATA_W  signed input sample.
REQ-013 out_valid / out_ready  output / input  1 each  output handshake; out_data is consumed when both are high.
REQ-014 out_data  output  DATA_W  signed scaled sample.
REQ-015 lfsr_state  output  LFSR_W  current epsilon, for debug.

Function
REQ-016 Pipeline: 2 stages (S1 multiply, S2 shift/saturate), so latency from accept to out_valid is 2 cycles when there is no stall.
REQ-017 advance = !out_valid || out_ready; in_ready = advance; both stages move only on advance; out_data and out_valid hold while stalled.
REQ-018 S1 captures product = in_data (signed) × {0, epsilon} (zero-extended) with full width DATA_W+LFSR_W+1, plus the mode bit and a valid bit.
REQ-019 S2: in scale mode, product >>> FRAC_BITS (arithmetic), then saturate to the signed DATA_W range; in bypass mode, in_data passes unchanged.
REQ-020 Saturation: a result above 2^(DATA_W-1)-1 clamps to the maximum; a result below -2^(DATA_W-1) clamps to the minimum; no wrap-around.
REQ-021 Epsilon is the LFSR value before the update on the accepting cycle; the LFSR steps exactly once per accepted beat, in both modes, and never on stall or idle cycles.
REQ-022 LFSR step: next = (state >> 1) XOR (state[0] ? TAPS : 0), then the MSB is XORed with the parity of in_data.
REQ-023 Lock-up guard: if next equals 0, load SEED instead.
REQ-024 seed_load has priority over a step on the same cycle: the LFSR loads seed_val (SEED if seed_val = 0), and the beat is still accepted using the old epsilon.
REQ-025 seed_load affects only the LFSR; in-flight pipeline data is unaffected.

Reset
REQ-026 While reset_n is low: LFSR = SEED; both stage valid bits = 0; out_valid = 0; out_data = 0; in_ready = 1 after release.
REQ-027 Reset during operation discards in-flight samples with no partial output; the first beat accepted after release uses epsilon = SEED.

Structure
REQ-028 A shared package holds default TAPS, default SEED, and the mode encoding constants MODE_BYPASS = 0, MODE_SCALE = 1.
REQ-029 One sub-module, noise_lfsr (Galois step, parity mix, zero guard, seed load, enable), is instantiated once; the rest is in noise_scaler.

Verification
REQ-030 Bypass: mode = 0, in_data = 20'sh00100, out_ready = 1 -> out_data = 20'sh00100 two cycles later; lfsr_state has changed.
REQ-031 Scale: seed_load with 16'h4000, then mode = 1, in_data = 1000 -> out_data = 500; repeat with in_data = -1000 -> out_data = -500.
REQ-032 Saturation: seed 16'hFFFF, in_data = 20'sh7FFFF -> 20'sh7FFFF; in_data = 20'sh80000 -> 20'sh80000.
REQ-033 Backpressure: out_ready low for 5 cycles with in_valid high -> in_ready low after the pipeline fills, no beat lost or duplicated, lfsr_state frozen; order preserved on release.
REQ-034 Zero guard and simultaneous events: seed_load with 0 -> lfsr_state = SEED; seed_load on an accepting cycle -> old epsilon used, new seed loaded.
REQ-035 Reset mid-stream: assert reset_n low with 2 beats in flight -> out_valid = 0 immediately, lfsr_state = SEED, no stale output after release.

Source files
------------

// File: rtl/noise_scaler_pkg.sv
// Shared constants for the noise scaler: default LFSR polynomial/seed and mode encoding.
package noise_scaler_pkg;

    localparam logic [15:0] TAPS_DEFAULT = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT = 16'h2E92;

    localparam logic MODE_BYPASS = 1'b0;
    localparam logic MODE_SCALE  = 1'b1;

endpackage

// File: rtl/noise_scaler_if.sv
// Sample stream bundle: input handshake into the scaler and output handshake out of it.
interface noise_scaler_if #(
    parameter int DATA_W = 20
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/noise_lfsr.sv
// Galois LFSR supplying epsilon; steps once per enable, mixes in data parity, never sticks at zero.
module noise_lfsr
    import noise_scaler_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = TAPS_DEFAULT,
    parameter logic [LFSR_W-1:0] SEED   = SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              step_en,
    input  logic              load_en,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              mix_bit,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;
    logic [LFSR_W-1:0] step_val;

    always_comb begin
        step_val = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        step_val[LFSR_W-1] = step_val[LFSR_W-1] ^ mix_bit;
        state_d = state_q;
        // A load wins over a step; a zero value from either source falls back to SEED.
        if (load_en) begin
            state_d = (load_val == '0) ? SEED : load_val;
        end else if (step_en) begin
            state_d = (step_val == '0) ? SEED : step_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/noise_scaler.sv
// Two-stage sample scaler: S1 multiplies by the LFSR epsilon, S2 shifts and saturates (or bypasses).
module noise_scaler
    import noise_scaler_pkg::*;
#(
    parameter int                DATA_W    = 20,
    parameter int                LFSR_W    = 16,
    parameter int                FRAC_BITS = 15,
    parameter logic [LFSR_W-1:0] TAPS      = TAPS_DEFAULT,
    parameter logic [LFSR_W-1:0] SEED      = SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mode,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_val,
    noise_scaler_if.slave     bus,
    output logic [LFSR_W-1:0] lfsr_state
);

    localparam int PROD_W = DATA_W + LFSR_W + 1;

    localparam logic signed [PROD_W-1:0] SAT_MAX =
        {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic                     advance;
    logic                     accept;
    logic [LFSR_W-1:0]        epsilon;
    logic [PROD_W-1:0]        a_ext;
    logic [PROD_W-1:0]        b_ext;
    logic signed [PROD_W-1:0] shifted;
    logic [DATA_W-1:0]        sat_val;

    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_mode_q,  s1_mode_d;
    logic signed [PROD_W-1:0] s1_prod_q,  s1_prod_d;
    logic [DATA_W-1:0]        s1_data_q,  s1_data_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        out_data_q,  out_data_d;

    noise_lfsr #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset_n  (reset_n),
        .step_en  (accept),
        .load_en  (seed_load),
        .load_val (seed_val),
        .mix_bit  (^bus.in_data),
        .state    (epsilon)
    );

    always_comb begin
        shifted = s1_prod_q >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_val = shifted[DATA_W-1:0];
        end
    end

    always_comb begin
        advance     = !out_valid_q || bus.out_ready;
        accept      = advance && bus.in_valid;
        // Signed sample times zero-extended epsilon; operands pre-extended so the product is exact.
        a_ext       = {{(PROD_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
        b_ext       = {{(PROD_W-LFSR_W){1'b0}}, epsilon};
        s1_valid_d  = s1_valid_q;
        s1_mode_d   = s1_mode_q;
        s1_prod_d   = s1_prod_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (advance) begin
            s1_valid_d  = bus.in_valid;
            out_valid_d = s1_valid_q;
            if (bus.in_valid) begin
                s1_mode_d = mode;
                s1_prod_d = a_ext * b_ext;
                s1_data_d = bus.in_data;
            end
            if (s1_valid_q) begin
                out_data_d = (s1_mode_q == MODE_SCALE) ? sat_val : s1_data_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= MODE_BYPASS;
            s1_prod_q   <= '0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_prod_q   <= s1_prod_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign lfsr_state    = epsilon;

endmodule

// File: tb/tb_noise_scaler.sv
// Self-checking bench for noise_scaler: directed corner cases then randomized traffic vs a queue model.
module tb_noise_scaler;
    import noise_scaler_pkg::*;

    localparam int DATA_W = 20;
    localparam int LFSR_W = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              mode = 1'b0;
    logic              seed_load = 1'b0;
    logic [LFSR_W-1:0] seed_val = '0;
    logic [LFSR_W-1:0] lfsr_state;

    noise_scaler_if #(.DATA_W(DATA_W)) bus ();

    noise_scaler #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .seed_load  (seed_load),
        .seed_val   (seed_val),
        .bus        (bus),
        .lfsr_state (lfsr_state)
    );

    always #5 clk = ~clk;

    int                vectors = 0;
    int                miscompares = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [LFSR_W-1:0] m_lfsr = SEED_DEFAULT;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vectors++;
        assert (obs === want)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [LFSR_W-1:0] ref_step(input logic [LFSR_W-1:0] s,
                                                  input logic [DATA_W-1:0] d);
        int n;
        n = int'(s) / 2;
        if (s[0]) n = n ^ int'(TAPS_DEFAULT);
        if (($countones(d) % 2) == 1) n = n ^ 32'h8000;
        if (n == 0) n = int'(SEED_DEFAULT);
        return n[LFSR_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] ref_out(input logic signed [DATA_W-1:0] d,
                                                 input logic m,
                                                 input logic [LFSR_W-1:0] eps);
        longint p;
        if (m == MODE_BYPASS) return d;
        p = (longint'(d) * longint'(eps)) >>> 15;
        if (p > 524287) p = 524287;
        else if (p < -524288) p = -524288;
        return p[DATA_W-1:0];
    endfunction

    task automatic tick();
        bit acc;
        @(negedge clk);
        check("lfsr_state", lfsr_state, m_lfsr);
        if (reset_n) begin
            check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", bus.out_valid, 1'b0);
                end else begin
                    check("out_data", bus.out_data, exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) exp_q.push_back(ref_out(bus.in_data, mode, m_lfsr));
            if (seed_load) m_lfsr = (seed_val == 0) ? SEED_DEFAULT : seed_val;
            else if (acc) m_lfsr = ref_step(m_lfsr, bus.in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [LFSR_W-1:0] s, input logic m,
                           input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] want);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        seed_load     = 1'b1;
        seed_val      = s;
        tick();
        seed_load     = 1'b0;
        mode          = m;
        bus.in_data   = d;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        tick();
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check(tag, bus.out_data, want);
        tick();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 20'h0);
        check("rst_lfsr", lfsr_state, SEED_DEFAULT);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);

        // Bypass with latency check
        mode         = MODE_BYPASS;
        bus.in_data  = 20'h00100;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("lat_stage1_not_valid", bus.out_valid, 1'b0);
        tick();
        check("lat_stage2_valid", bus.out_valid, 1'b1);
        check("bypass_data", bus.out_data, 20'h00100);
        check("bypass_lfsr_moved", lfsr_state != SEED_DEFAULT, 1'b1);
        tick();

        // Scale and saturation
        run_one("scale_pos", 16'h4000, MODE_SCALE, 20'd1000, 20'd500);
        run_one("scale_neg", 16'h4000, MODE_SCALE, 20'hFFC18, 20'hFFE0C);
        run_one("sat_max", 16'hFFFF, MODE_SCALE, 20'h7FFFF, 20'h7FFFF);
        run_one("sat_min", 16'hFFFF, MODE_SCALE, 20'h80000, 20'h80000);

        // Zero-seed guard
        seed_load = 1'b1;
        seed_val  = 16'h0000;
        tick();
        seed_load = 1'b0;
        check("zero_seed_guard", lfsr_state, SEED_DEFAULT);

        // Seed load on an accepting cycle: old epsilon used, new seed loaded
        seed_load    = 1'b1;
        seed_val     = 16'h1234;
        mode         = MODE_SCALE;
        bus.in_data  = 20'h3A5C7;
        bus.in_valid = 1'b1;
        tick();
        seed_load    = 1'b0;
        bus.in_valid = 1'b0;
        check("sim_seed_loaded", lfsr_state, 16'h1234);
        repeat (2) tick();

        // Backpressure
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = DATA_W'($urandom);
            mode        = 1'($urandom_range(0, 1));
            tick();
        end
        check("bp_in_ready_low", bus.in_ready, 1'b0);
        check("bp_inflight", exp_q.size(), 2);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        repeat (4) tick();
        check("bp_drained", exp_q.size(), 0);

        // Reset with two beats in flight
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_data = DATA_W'($urandom);
            tick();
        end
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_out_data", bus.out_data, 20'h0);
        check("midrst_lfsr", lfsr_state, SEED_DEFAULT);
        exp_q.delete();
        m_lfsr = SEED_DEFAULT;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            mode          = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       bus.in_data = 20'h7FFFF;
                1:       bus.in_data = 20'h80000;
                default: bus.in_data = DATA_W'($urandom);
            endcase
            seed_load = ($urandom_range(0, 19) == 0);
            seed_val  = ($urandom_range(0, 3) == 0) ? 16'h0000 : LFSR_W'($urandom);
            tick();
        end
        seed_load     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) tick();
        check("final_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
